id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the 5-stage MIPS core.
- Captures decode-stage control, register operands and instruction fields every cycle.
- Inserts a bubble on FlushE from the hazard unit and holds on StallE.
- Produces the E-stage signals the hazard unit consumes (RsE, RtE, WriteRegE, RegWriteE, MemtoRegE), a valid flag and a saturating bubble counter for debug.

Parameters:
DATA_WIDTH, 32, operand, immediate and PC width
REG_ADDR_WIDTH, 5, register-file address width (Rs/Rt/Rd/WriteReg)
ALU_CTRL_WIDTH, 3, ALUControl width
CNT_WIDTH, 16, bubble counter width

Ports:
CLK  in  1  core clock, all state on rising edge
RST  in  1  synchronous active-high reset
FlushE  in  1  from hazard unit: load bubble into E
StallE  in  1  hold E contents (tied 0 in current core, reserved for multicycle EX)
RegWriteD  in  1  decode control
MemtoRegD  in  1  decode control
MemWriteD  in  1  decode control
ALUSrcD  in  1  decode control
RegDstD  in  1  1 = write Rd, 0 = write Rt
ALUControlD  in  ALU_CTRL_WIDTH  decode control
RD1D  in  DATA_WIDTH  register file port 1
RD2D  in  DATA_WIDTH  register file port 2
SignImmD  in  DATA_WIDTH  sign-extended immediate
PCPlus4D  in  DATA_WIDTH  PC+4 of decode instruction
RsD  in  REG_ADDR_WIDTH  instr[25:21]
RtD  in  REG_ADDR_WIDTH  instr[20:16]
RdD  in  REG_ADDR_WIDTH  instr[15:11]
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered control
ALUControlE  out  ALU_CTRL_WIDTH  registered
RD1E, RD2E, SignImmE, PCPlus4E  out  DATA_WIDTH each  registered
RsE, RtE, RdE  out  REG_ADDR_WIDTH each  registered
WriteRegE  out  REG_ADDR_WIDTH  RegDstE ? RdE : RtE (combinational from registers)
ValidE  out  1  E holds a real instruction
BubbleCnt  out  CNT_WIDTH  number of flush cycles since reset, saturating

Behaviour:
- One-cycle latency: D inputs at edge N appear on E outputs after edge N.
- Per-edge priority: RST > FlushE > StallE > load.
- RST: every registered output, ValidE and BubbleCnt = 0; therefore WriteRegE = 0.
- FlushE=1: every field cleared to 0, including RsE/RtE/RdE, so no false forwarding match against $0; ValidE=0; BubbleCnt increments.
- StallE=1, FlushE=0: all fields, ValidE and BubbleCnt hold.
- Load: all fields take D values; ValidE=1.
- Flush and stall asserted together: flush wins; a bubble is loaded.
- BubbleCnt: +1 per flush edge; saturates at 2^CNT_WIDTH-1 and does not wrap; cleared only by RST.
- WriteRegE has no clock-to-output beyond the mux; RegDstE=0 selects RtE.
- Reset mid-stream: the next edge with RST=1 discards the in-flight instruction; the first edge after RST deasserts loads normally.
- No X propagation: unknown D inputs are captured as-is; the block adds no X.

Decomposition:
- Shared package (core_pkg): DATA_WIDTH, REG_ADDR_WIDTH and ALU_CTRL_WIDTH constants, plus ALUControl encodings (AND=000, OR=001, ADD=010, SUB=110, SLT=111) for bench readability.
- Sub-module pipe_reg_en_clr: parameter WIDTH; ports CLK, RST, CLR, EN, D, Q; priority RST/CLR > EN.
- Instantiate one pipe_reg_en_clr per field group (control, data, address) with CLR=FlushE and EN=~StallE.
- Counter and WriteReg mux stay in the top module.

Test Plan:
- Reset: RST=1 for 2 cycles with nonzero D inputs -> all E outputs 0, ValidE=0, BubbleCnt=0.
- Load: RegWriteD=1, RegDstD=1, RsD=5, RtD=6, RdD=7, RD1D=0x1234, ALUControlD=010, one edge -> RegWriteE=1, RsE=5, RtE=6, WriteRegE=7, RD1E=0x1234, ValidE=1. Same inputs with RegDstD=0 -> WriteRegE=6.
- Flush (lw-use bubble): MemtoRegD=1, RtD=8 loaded, then FlushE=1 for one edge -> every E field 0, ValidE=0, BubbleCnt=1. Next edge FlushE=0 -> D values appear.
- Stall hold: load RsD=3, then StallE=1 for 3 edges while D changes to RsD=9 -> RsE stays 3, BubbleCnt unchanged. Release -> RsE=9 after one edge.
- Flush with stall: FlushE=1 and StallE=1 on the same edge -> bubble loaded, BubbleCnt increments.
- Saturation and reset mid-run: CNT_WIDTH=4, 20 consecutive flush edges -> BubbleCnt=15 and holds; RST=1 for one edge -> BubbleCnt=0 and outputs 0; next load edge is captured normally.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared MIPS core widths and ALUControl encodings
package core_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int ALU_CTRL_WIDTH = 3;

   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/pipe_reg_en_clr.sv
// rtl/pipe_reg_en_clr.sv - pipeline register with sync reset, clear and enable
module pipe_reg_en_clr #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         r_q <= '0;
      end else if (EN) begin
         r_q <= D;
      end
   end

   assign Q = r_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - Decode-to-Execute pipeline register with bubble insertion
module id_ex_pipe_reg #(
   parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
   parameter int ALU_CTRL_WIDTH = core_pkg::ALU_CTRL_WIDTH,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      FlushE,
   input  logic                      StallE,
   input  logic                      RegWriteD,
   input  logic                      MemtoRegD,
   input  logic                      MemWriteD,
   input  logic                      ALUSrcD,
   input  logic                      RegDstD,
   input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
   input  logic [DATA_WIDTH-1:0]     RD1D,
   input  logic [DATA_WIDTH-1:0]     RD2D,
   input  logic [DATA_WIDTH-1:0]     SignImmD,
   input  logic [DATA_WIDTH-1:0]     PCPlus4D,
   input  logic [REG_ADDR_WIDTH-1:0] RsD,
   input  logic [REG_ADDR_WIDTH-1:0] RtD,
   input  logic [REG_ADDR_WIDTH-1:0] RdD,
   output logic                      RegWriteE,
   output logic                      MemtoRegE,
   output logic                      MemWriteE,
   output logic                      ALUSrcE,
   output logic                      RegDstE,
   output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
   output logic [DATA_WIDTH-1:0]     RD1E,
   output logic [DATA_WIDTH-1:0]     RD2E,
   output logic [DATA_WIDTH-1:0]     SignImmE,
   output logic [DATA_WIDTH-1:0]     PCPlus4E,
   output logic [REG_ADDR_WIDTH-1:0] RsE,
   output logic [REG_ADDR_WIDTH-1:0] RtE,
   output logic [REG_ADDR_WIDTH-1:0] RdE,
   output logic [REG_ADDR_WIDTH-1:0] WriteRegE,
   output logic                      ValidE,
   output logic [CNT_WIDTH-1:0]      BubbleCnt
);
   localparam int CTRL_W = ALU_CTRL_WIDTH + 6;
   localparam int DATA_W = 4 * DATA_WIDTH;
   localparam int ADDR_W = 3 * REG_ADDR_WIDTH;

   logic [CTRL_W-1:0] w_ctrl_d, w_ctrl_q;
   logic [DATA_W-1:0] w_data_d, w_data_q;
   logic [ADDR_W-1:0] w_addr_d, w_addr_q;
   logic              w_en;
   logic [CNT_WIDTH-1:0] r_bubble_cnt;

   assign w_en = ~StallE;

   // Valid rides with the control group so a flush clears it with the rest of the bubble.
   assign w_ctrl_d = {1'b1, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD};
   assign w_data_d = {RD1D, RD2D, SignImmD, PCPlus4D};
   assign w_addr_d = {RsD, RtD, RdD};

   pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl (
      .CLK(CLK), .RST(RST), .CLR(FlushE), .EN(w_en), .D(w_ctrl_d), .Q(w_ctrl_q)
   );

   pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data (
      .CLK(CLK), .RST(RST), .CLR(FlushE), .EN(w_en), .D(w_data_d), .Q(w_data_q)
   );

   pipe_reg_en_clr #(.WIDTH(ADDR_W)) u_addr (
      .CLK(CLK), .RST(RST), .CLR(FlushE), .EN(w_en), .D(w_addr_d), .Q(w_addr_q)
   );

   assign {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE} = w_ctrl_q;
   assign {RD1E, RD2E, SignImmE, PCPlus4E} = w_data_q;
   assign {RsE, RtE, RdE} = w_addr_q;

   assign WriteRegE = RegDstE ? RdE : RtE;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_bubble_cnt <= '0;
      end else if (FlushE && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign BubbleCnt = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
   import core_pkg::*;

   logic        CLK = 1'b0;
   logic        RST, FlushE, StallE;
   logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D;
   logic [4:0]  RsD, RtD, RdD;
   logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;
   logic [4:0]  RsE, RtE, RdE, WriteRegE;
   logic        ValidE;
   logic [3:0]  BubbleCnt;

   int checks = 0;
   int failures = 0;

   id_ex_pipe_reg #(.CNT_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .FlushE(FlushE), .StallE(StallE),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
      .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
      .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
      .ValidE(ValidE), .BubbleCnt(BubbleCnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_ctrl"}, {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}, 64'h0);
      check({tag, "_rd1"}, RD1E, 64'h0);
      check({tag, "_rd2"}, RD2E, 64'h0);
      check({tag, "_imm"}, SignImmE, 64'h0);
      check({tag, "_pc4"}, PCPlus4E, 64'h0);
      check({tag, "_addr"}, {RsE, RtE, RdE}, 64'h0);
      check({tag, "_wreg"}, WriteRegE, 64'h0);
      check({tag, "_valid"}, ValidE, 64'h0);
   endtask

   initial begin
      RST = 1'b1; FlushE = 1'b0; StallE = 1'b0;
      RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1; RegDstD = 1'b1;
      ALUControlD = ALU_SLT; RD1D = 32'hDEAD_BEEF; RD2D = 32'hCAFE_F00D;
      SignImmD = 32'hFFFF_FFFC; PCPlus4D = 32'h0040_0004; RsD = 5'd31; RtD = 5'd30; RdD = 5'd29;
      tick(); tick();
      check_bubble("reset");
      check("reset_cnt", BubbleCnt, 64'h0);

      RST = 1'b0;
      RegWriteD = 1'b1; MemtoRegD = 1'b0; MemWriteD = 1'b0; ALUSrcD = 1'b0; RegDstD = 1'b1;
      ALUControlD = ALU_ADD; RD1D = 32'h0000_1234; RD2D = 32'h0000_5678;
      SignImmD = 32'h0000_0010; PCPlus4D = 32'h0040_0008; RsD = 5'd5; RtD = 5'd6; RdD = 5'd7;
      tick();
      check("load_regwrite", RegWriteE, 64'h1);
      check("load_rs", RsE, 64'd5);
      check("load_rt", RtE, 64'd6);
      check("load_wreg_rd", WriteRegE, 64'd7);
      check("load_rd1", RD1E, 64'h1234);
      check("load_rd2", RD2E, 64'h5678);
      check("load_imm", SignImmE, 64'h10);
      check("load_pc4", PCPlus4E, 64'h0040_0008);
      check("load_alu", ALUControlE, 64'(ALU_ADD));
      check("load_valid", ValidE, 64'h1);

      RegDstD = 1'b0;
      tick();
      check("load_wreg_rt", WriteRegE, 64'd6);
      check("load_regdst0", RegDstE, 64'h0);

      MemtoRegD = 1'b1; RtD = 5'd8; ALUControlD = ALU_SUB;
      tick();
      check("lw_memtoreg", MemtoRegE, 64'h1);
      check("lw_rt", RtE, 64'd8);

      FlushE = 1'b1;
      tick();
      check_bubble("flush");
      check("flush_cnt", BubbleCnt, 64'd1);

      FlushE = 1'b0;
      tick();
      check("after_flush_memtoreg", MemtoRegE, 64'h1);
      check("after_flush_rt", RtE, 64'd8);
      check("after_flush_alu", ALUControlE, 64'(ALU_SUB));
      check("after_flush_valid", ValidE, 64'h1);
      check("after_flush_cnt", BubbleCnt, 64'd1);

      RsD = 5'd3;
      tick();
      check("stall_pre_rs", RsE, 64'd3);
      StallE = 1'b1; RsD = 5'd9; RD1D = 32'h0000_9999; ALUControlD = ALU_OR;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_rs", RsE, 64'd3);
         check("stall_rd1", RD1E, 64'h1234);
         check("stall_alu", ALUControlE, 64'(ALU_SUB));
         check("stall_cnt", BubbleCnt, 64'd1);
         check("stall_valid", ValidE, 64'h1);
      end
      StallE = 1'b0;
      tick();
      check("release_rs", RsE, 64'd9);
      check("release_rd1", RD1E, 64'h9999);
      check("release_alu", ALUControlE, 64'(ALU_OR));

      FlushE = 1'b1; StallE = 1'b1;
      tick();
      check_bubble("flush_stall");
      check("flush_stall_cnt", BubbleCnt, 64'd2);
      StallE = 1'b0;

      for (int i = 1; i <= 20; i++) begin
         tick();
         check("sat_cnt", BubbleCnt, (2 + i > 15) ? 64'd15 : 64'(2 + i));
      end
      check_bubble("sat_bubble");

      FlushE = 1'b0; RST = 1'b1;
      tick();
      check_bubble("midreset");
      check("midreset_cnt", BubbleCnt, 64'd0);

      RST = 1'b0;
      RegWriteD = 1'b0; MemWriteD = 1'b1; ALUSrcD = 1'b1; RegDstD = 1'b0; MemtoRegD = 1'b0;
      ALUControlD = ALU_AND; RD2D = 32'hA5A5_0001; SignImmD = 32'h0000_0024;
      RsD = 5'd17; RtD = 5'd18; RdD = 5'd0;
      tick();
      check("post_reset_memwrite", MemWriteE, 64'h1);
      check("post_reset_alusrc", ALUSrcE, 64'h1);
      check("post_reset_regwrite", RegWriteE, 64'h0);
      check("post_reset_rd2", RD2E, 64'hA5A5_0001);
      check("post_reset_imm", SignImmE, 64'h24);
      check("post_reset_wreg", WriteRegE, 64'd18);
      check("post_reset_alu", ALUControlE, 64'(ALU_AND));
      check("post_reset_valid", ValidE, 64'h1);
      check("post_reset_cnt", BubbleCnt, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
